// File: rtl/score_bcd_if.sv
// Handshake and data bundle between the game-logic score source and the BCD converter.
// The master requests conversions; the slave reports progress and results.
interface score_bcd_if #(
    parameter int INPUT_WIDTH = 14,
    parameter int DIGITS      = 4
);
    logic                   start;
    logic [INPUT_WIDTH-1:0] bin_in;
    logic                   busy;
    logic                   done;
    logic [4*DIGITS-1:0]    bcd_out;
    logic                   overflow;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out,
        input  overflow
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out,
        output overflow
    );
endinterface

// File: rtl/score_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Results saturate to all nines above the displayable range and are held between conversions.
module score_bcd_converter #(
    parameter int INPUT_WIDTH = 14,
    parameter int DIGITS      = 4
) (
    input  logic       clk,
    input  logic       rst,
    score_bcd_if.slave bus
);
    localparam int          BCD_WIDTH = 4 * DIGITS;
    localparam int          CNT_WIDTH = $clog2(INPUT_WIDTH + 1);
    localparam logic [31:0] MAX_VAL   = 32'(10 ** DIGITS - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]             state;
    logic [INPUT_WIDTH-1:0] shift_reg;
    logic [BCD_WIDTH-1:0]   scratch;
    logic [BCD_WIDTH-1:0]   adjusted;
    logic [CNT_WIDTH-1:0]   count;
    logic                   ovf_pending;
    logic                   busy_q;
    logic                   done_q;
    logic [BCD_WIDTH-1:0]   bcd_q;
    logic                   overflow_q;

    // Add-3 correction is per digit with no carry into the neighbour digit.
    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            shift_reg   <= '0;
            scratch     <= '0;
            count       <= '0;
            ovf_pending <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bcd_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shift_reg   <= bus.bin_in;
                        scratch     <= '0;
                        count       <= '0;
                        ovf_pending <= (32'(bus.bin_in) > MAX_VAL);
                        busy_q      <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    // The final edge publishes the result instead of shifting again.
                    if (count == CNT_WIDTH'(INPUT_WIDTH)) begin
                        bcd_q      <= ovf_pending ? {DIGITS{4'h9}} : scratch;
                        overflow_q <= ovf_pending;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        scratch   <= {adjusted[BCD_WIDTH-2:0], shift_reg[INPUT_WIDTH-1]};
                        shift_reg <= {shift_reg[INPUT_WIDTH-2:0], 1'b0};
                        count     <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_score_bcd_converter.sv
// Self-checking bench for score_bcd_converter against a decimal-arithmetic reference model.
module tb_score_bcd_converter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    score_bcd_if #(.INPUT_WIDTH(14), .DIGITS(4)) bus ();

    score_bcd_converter #(.INPUT_WIDTH(14), .DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits by plain division, saturating at 9999.
    function automatic logic [15:0] ref_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000 % 10), 4'(s / 100 % 10), 4'(s / 10 % 10), 4'(s % 10)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full conversion: start pulse, bounded wait for done, then result and pulse-width checks.
    task automatic applyStimulus(input int v, input string tag);
        int  cycles;
        bit  busy_ok;
        bus.bin_in = 14'(v);
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.bin_in = 14'($urandom_range(0, 16383));
        checkOutput({tag, "_busy_at_accept"}, 32'(bus.busy), 32'd1);
        cycles  = 1;
        busy_ok = 1'b1;
        while (cycles < 24) begin
            tick();
            cycles++;
            if (bus.done) break;
            if (!bus.busy) busy_ok = 1'b0;
        end
        checkOutput({tag, "_latency"}, 32'(cycles), 32'd16);
        checkOutput({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
        checkOutput({tag, "_bcd"}, 32'(bus.bcd_out), 32'(ref_bcd(v)));
        checkOutput({tag, "_ovf"}, 32'(bus.overflow), 32'(v > 9999));
        checkOutput({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        tick();
        checkOutput({tag, "_done_single"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int done_count;
        int k;
        int done_at[3];
        int cyc;
        int v;

        total      = 0;
        bad        = 0;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        rst        = 1'b1;

        // Asynchronous reset, asserted and checked between clock edges.
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_bcd", 32'(bus.bcd_out), 32'd0);
        checkOutput("reset_ovf", 32'(bus.overflow), 32'd0);
        tick();
        tick();
        #2 rst = 1'b1;
        tick();

        applyStimulus(1234, "basic_1234");
        applyStimulus(0, "bnd_0");
        applyStimulus(9, "bnd_9");
        applyStimulus(10, "bnd_10");
        applyStimulus(9999, "bnd_9999");
        applyStimulus(12000, "sat_12000");
        applyStimulus(42, "after_sat_42");

        // Busy rejection: a second start mid-conversion must be ignored.
        bus.bin_in = 14'd500;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bus.bin_in = 14'd777;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        done_count = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.done) begin
                done_count++;
                checkOutput("reject_bcd", 32'(bus.bcd_out), 32'h0500);
            end
        end
        checkOutput("reject_done_count", 32'(done_count), 32'd1);
        checkOutput("reject_hold", 32'(bus.bcd_out), 32'h0500);

        // Continuous mode: start held high, value stepped after each done.
        bus.bin_in = 14'd1;
        bus.start  = 1'b1;
        k   = 0;
        cyc = 0;
        while (cyc < 80 && k < 3) begin
            tick();
            cyc++;
            if (bus.done) begin
                done_at[k] = cyc;
                checkOutput($sformatf("cont_bcd_%0d", k + 1), 32'(bus.bcd_out), 32'(ref_bcd(k + 1)));
                k++;
                bus.bin_in = 14'(k + 1);
                if (k == 3) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        checkOutput("cont_count", 32'(k), 32'd3);
        if (k == 3) begin
            checkOutput("cont_first", 32'(done_at[0]), 32'd16);
            checkOutput("cont_period1", 32'(done_at[1] - done_at[0]), 32'd16);
            checkOutput("cont_period2", 32'(done_at[2] - done_at[1]), 32'd16);
        end
        tick();

        // Abort: reset during the shift phase gives no done and clears outputs.
        bus.bin_in = 14'd321;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        #2 rst = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_bcd", 32'(bus.bcd_out), 32'd0);
        checkOutput("abort_ovf", 32'(bus.overflow), 32'd0);
        #2 rst = 1'b1;
        done_count = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (bus.done) done_count++;
        end
        checkOutput("abort_no_done", 32'(done_count), 32'd0);
        checkOutput("abort_bcd_after", 32'(bus.bcd_out), 32'd0);

        // Random values, biased toward the saturation threshold.
        for (int i = 0; i < 12; i++) begin
            if (i % 3 == 0) v = 9990 + int'($urandom_range(0, 20));
            else v = int'($urandom_range(0, 16383));
            applyStimulus(v, $sformatf("rand_%0d", v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/score_bcd_converter.md
Name: score_bcd_converter

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the draw stage's `score` input. Converts the game-logic binary score into packed BCD digits for the on-screen score display.
- Holds the last converted value stable between conversions, so the display never shows partial results.

Parameters:
- INPUT_WIDTH, 14, width of the binary input; 14 bits covers 0..16383.
- DIGITS, 4, number of BCD digits produced; output width is 4*DIGITS.
- Derived localparam MAX_VAL = 10^DIGITS - 1 (9999 at defaults); this is the saturation threshold.

Ports:
- clk  in  1  single clock domain; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  conversion request; sampled only in IDLE.
- bin_in  in  INPUT_WIDTH  binary value; captured on the accepting edge.
- busy  out  1  high while a conversion is in progress.
- done  out  1  single-cycle pulse when bcd_out/overflow are updated.
- bcd_out  out  4*DIGITS  packed BCD, digit 0 in [3:0]; held between conversions.
- overflow  out  1  1 if the last converted value exceeded MAX_VAL.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, bcd_out=0, overflow=0; shift register, scratch and bit counter cleared.
- States: IDLE and SHIFT. There is no separate DONE state; done is registered on the SHIFT->IDLE transition.
- IDLE, start=1 at edge E0:
  - Capture bin_in into the input shift register; clear the BCD scratch; counter=0.
  - Capture ovf_pending = (bin_in > MAX_VAL).
  - Go to SHIFT; busy=1 from E0.
- IDLE, start=0: hold all state; done=0.
- SHIFT, each edge E1..E(INPUT_WIDTH):
  - For every scratch digit >= 5, add 3 (per digit, 4-bit, no carry between digits).
  - Then shift {scratch, input reg} left by 1; the input MSB enters scratch bit 0.
  - Counter increments.
- Edge E(INPUT_WIDTH+1), counter == INPUT_WIDTH:
  - bcd_out <= ovf_pending ? all digits 9 : scratch.
  - overflow <= ovf_pending; done=1 for exactly this cycle; busy=0; state=IDLE.
- Latency: with start sampled at E0, done and bcd_out update at E0+INPUT_WIDTH+1 (E15 at defaults).
- Earliest next accept is E0+INPUT_WIDTH+2. With start tied high, a conversion completes every INPUT_WIDTH+2 cycles (16 at defaults).
- start during SHIFT is ignored. No queuing and no restart.
- bin_in changes after E0 have no effect on the conversion in flight.
- bcd_out and overflow change only on a done cycle; otherwise they are held.
- Counter width is clog2(INPUT_WIDTH+1). Scratch width is 4*DIGITS; bits shifted beyond it are discarded, which only matters in the overflow case, where saturation replaces the result.
- Reset mid-conversion: abort immediately; outputs return to reset values; no done pulse.
- bin_in=0 produces bcd_out=0 after the full latency; there is no early exit, so latency is constant.

Test Plan:
- Reset: assert rst=0 at an arbitrary time -> busy=0, done=0, bcd_out=16'h0000, overflow=0 asynchronously, before the next clk edge.
- Basic conversion: bin_in=1234, start pulse at E0 -> busy=1 over E0..E14; done=1 only in the cycle after E15; bcd_out=16'h1234; overflow=0.
- Boundary values, each run separately:
  - 0 -> 16'h0000.
  - 9 -> 16'h0009.
  - 10 -> 16'h0010.
  - 9999 -> 16'h9999 with overflow=0.
- Saturation: bin_in=12000 -> bcd_out=16'h9999, overflow=1. Then bin_in=42 -> bcd_out=16'h0042, overflow=0.
- Input stability and busy rejection:
  - Convert 500, then change bin_in to 777 and pulse start at E5 -> result 16'h0500, only one done pulse.
  - bcd_out holds 16'h0500 until the next accepted conversion.
- Continuous and abort:
  - start held high with bin_in stepping 1,2,3 -> done every 16 cycles, giving 16'h0001, 16'h0002, 16'h0003.
  - rst pulse at E7 of a conversion -> no done; outputs return to 0.
